// File: rtl/scene_int_issue_pkg.sv
// scene_int_issue_pkg: ray/float types plus the issue/collect types shared by the scene_int front end.
package scene_int_issue_pkg;
    localparam int SI_LAT_DEFAULT = 24;
    localparam int SI_ID_W = 8;
    typedef logic [31:0] float_t;
    typedef struct packed {
        float_t x;
        float_t y;
        float_t z;
    } vec3_t;
    typedef struct packed {
        vec3_t origin;
        vec3_t dir;
    } prg_ray_t;
    typedef enum logic [1:0] {IDLE, AX0, AX1, AX2} si_issue_state_t;
    typedef struct packed {
        logic [SI_ID_W-1:0] id;
        float_t             tmin;
        float_t             tmax;
        logic               miss;
        logic               shadow;
    } si_result_t;
    typedef struct packed {
        logic               valid;
        logic [SI_ID_W-1:0] id;
        logic               shadow;
    } si_tag_t;
endpackage

// File: rtl/scene_int_issue_if.sv
// scene_int_issue_if: ray intake, scene_int beat drive/return and result handshake bundle.
interface scene_int_issue_if #(parameter int ID_W = scene_int_issue_pkg::SI_ID_W);
    import scene_int_issue_pkg::*;
    prg_ray_t        ray_in;
    logic [ID_W-1:0] ray_id;
    logic            ray_shadow;
    logic            ray_valid;
    logic            ray_ready;
    prg_ray_t        si_ray;
    logic            si_v0;
    logic            si_v1;
    logic            si_v2;
    logic            si_isShadow;
    float_t          tmin_scene;
    float_t          tmax_scene;
    logic            miss;
    logic            res_valid;
    logic            res_ready;
    logic [ID_W-1:0] res_id;
    float_t          res_tmin;
    float_t          res_tmax;
    logic            res_miss;
    logic            res_shadow;
    modport slave (
        input  ray_in, ray_id, ray_shadow, ray_valid, tmin_scene, tmax_scene, miss, res_ready,
        output ray_ready, si_ray, si_v0, si_v1, si_v2, si_isShadow,
               res_valid, res_id, res_tmin, res_tmax, res_miss, res_shadow
    );
    modport master (
        output ray_in, ray_id, ray_shadow, ray_valid, tmin_scene, tmax_scene, miss, res_ready,
        input  ray_ready, si_ray, si_v0, si_v1, si_v2, si_isShadow,
               res_valid, res_id, res_tmin, res_tmax, res_miss, res_shadow
    );
endinterface

// File: rtl/scene_int_issue_sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO; head reads as zero while empty.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rptr, wptr;
    logic          do_push, do_pop;
    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rptr];
    always_ff @(posedge clk)
        if (do_push) mem[wptr] <= din;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr == AW'(DEPTH - 1) ? '0 : wptr + AW'(1);
            if (do_pop) rptr <= rptr == AW'(DEPTH - 1) ? '0 : rptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
endmodule

// File: rtl/scene_int_issue.sv
// scene_int_issue: serialises rays into three scene_int axis beats and collects tagged results in order.
// Credits cover rays in flight plus buffered results, so the result FIFO can never overflow.
module scene_int_issue import scene_int_issue_pkg::*; #(
    parameter int SI_LAT     = SI_LAT_DEFAULT,
    parameter int FIFO_DEPTH = 8,
    parameter int ID_W       = SI_ID_W
) (
    input logic              clk,
    input logic              rst,
    scene_int_issue_if.slave bus
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    si_issue_state_t        state, state_nx;
    logic [CW-1:0]          cnt, fifo_count;
    logic [ID_W-1:0]        hold_id;
    si_tag_t [SI_LAT-1:0]   tag;
    si_result_t             push_data, head;
    logic                   accept, pop, push, full, empty;
    // rst gates ready so nothing is offered while the block is held in reset
    assign bus.ray_ready = rst && (state == IDLE || state == AX2) && cnt < CW'(FIFO_DEPTH);
    assign accept        = bus.ray_valid && bus.ray_ready;
    assign pop           = bus.res_valid && bus.res_ready;
    assign push          = tag[SI_LAT-1].valid;
    always_comb
        state_nx = state == AX0 ? AX1 : state == AX1 ? AX2 : accept ? AX0 : IDLE;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state           <= IDLE;
            bus.si_v0       <= 1'b0;
            bus.si_v1       <= 1'b0;
            bus.si_v2       <= 1'b0;
            bus.si_ray      <= '0;
            bus.si_isShadow <= 1'b0;
            hold_id         <= '0;
        end else begin
            state     <= state_nx;
            bus.si_v0 <= state_nx == AX0;
            bus.si_v1 <= state_nx == AX1;
            bus.si_v2 <= state_nx == AX2;
            if (accept) begin
                bus.si_ray      <= bus.ray_in;
                bus.si_isShadow <= bus.ray_shadow;
                hold_id         <= bus.ray_id;
            end
        end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            cnt <= '0;
            tag <= '0;
        end else begin
            cnt <= cnt + CW'(accept) - CW'(pop);
            tag <= {tag[SI_LAT-2:0], si_tag_t'{valid: state == AX0, id: hold_id, shadow: bus.si_isShadow}};
        end
    assign push_data = '{id: tag[SI_LAT-1].id, tmin: bus.tmin_scene, tmax: bus.tmax_scene,
                         miss: bus.miss, shadow: tag[SI_LAT-1].shadow};
    sync_fifo #(.W($bits(si_result_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .rst(rst), .push(push), .din(push_data), .pop(pop),
        .dout(head), .full(full), .empty(empty), .count(fifo_count)
    );
    assign bus.res_valid  = !empty;
    assign bus.res_id     = head.id;
    assign bus.res_tmin   = head.tmin;
    assign bus.res_tmax   = head.tmax;
    assign bus.res_miss   = head.miss;
    assign bus.res_shadow = head.shadow;
    always @(posedge clk)
        if (rst) begin
            assert (!(push && full && !pop));
            assert (cnt <= CW'(FIFO_DEPTH));
            assert (fifo_count <= cnt);
        end
endmodule

// File: tb/tb_scene_int_issue.sv
// tb_scene_int_issue: directed checks of beat issue, ordering, credit backpressure and reset for scene_int_issue.
module tb_scene_int_issue;
    import scene_int_issue_pkg::*;
    localparam int SI_LAT = SI_LAT_DEFAULT;
    localparam float_t ONE = 32'h3F80_0000, NEG1 = 32'hBF80_0000;
    logic clk = 1'b0, rst = 1'b1;
    int checks = 0, errors = 0, cyc = 0;
    scene_int_issue_if bus ();
    scene_int_issue dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // behavioural scene_int: sample on the v0 beat, answer SI_LAT cycles later
    float_t m_tmin [SI_LAT];
    float_t m_tmax [SI_LAT];
    logic   m_miss [SI_LAT];
    always @(posedge clk) begin
        for (int i = SI_LAT - 1; i > 0; i--) begin
            m_tmin[i] <= m_tmin[i-1];
            m_tmax[i] <= m_tmax[i-1];
            m_miss[i] <= m_miss[i-1];
        end
        m_tmin[0] <= bus.si_v0 ? bus.si_ray.origin.x : 32'h0;
        m_tmax[0] <= bus.si_v0 ? bus.si_ray.origin.y : 32'h0;
        m_miss[0] <= bus.si_v0 ? bus.si_ray.dir.x[31] : 1'b0;
    end
    assign bus.tmin_scene = m_tmin[SI_LAT-1];
    assign bus.tmax_scene = m_tmax[SI_LAT-1];
    assign bus.miss       = m_miss[SI_LAT-1];

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    function automatic prg_ray_t mk(input float_t ox, oy, oz, dx, dy, dz);
        mk = {ox, oy, oz, dx, dy, dz};
    endfunction
    task automatic send(input prg_ray_t r, input logic [7:0] id, input logic sh, input int limit,
                        output int acc, output logic ok);
        bus.ray_in = r; bus.ray_id = id; bus.ray_shadow = sh; bus.ray_valid = 1'b1;
        ok = 1'b0; acc = 0;
        for (int i = 0; i < limit && !bus.ray_ready; i++) step();
        if (bus.ray_ready) begin
            step();
            acc = cyc;
            ok = 1'b1;
        end
    endtask
    task automatic wait_res(input string tag, input int limit);
        for (int i = 0; i < limit && !bus.res_valid; i++) step();
        chk({tag, " res_valid"}, bus.res_valid, 1'b1);
    endtask
    task automatic chk_zero(input string tag);
        chk({tag, " ctl"}, {bus.ray_ready, bus.si_v0, bus.si_v1, bus.si_v2, bus.si_isShadow,
                            bus.res_valid, bus.res_miss, bus.res_shadow}, 8'h0);
        chk({tag, " si_ray"}, bus.si_ray, 192'h0);
        chk({tag, " res"}, {bus.res_id, bus.res_tmin, bus.res_tmax}, 72'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a, last, n, seen;
        int acc [6];
        int rc [6];
        logic ok;
        prg_ray_t r1;
        bus.ray_in = '0; bus.ray_id = '0; bus.ray_shadow = 1'b0; bus.ray_valid = 1'b0; bus.res_ready = 1'b0;
        #2 rst = 1'b0;
        step(2);
        chk_zero("reset");
        rst = 1'b1;
        step();
        chk("idle ready", bus.ray_ready, 1'b1);

        // single ray
        r1 = mk(32'h4000_0000, 32'h40C0_0000, 32'hC0A0_0000, ONE, 32'h0, ONE);
        send(r1, 8'h11, 1'b0, 5, a, ok);
        bus.ray_valid = 1'b0;
        chk("t1 accept", ok, 1'b1);
        chk("t1 beat0", {bus.si_v0, bus.si_v1, bus.si_v2, bus.si_isShadow}, 4'b1000);
        chk("t1 si_ray", bus.si_ray, r1);
        step();
        chk("t1 beat1", {bus.si_v0, bus.si_v1, bus.si_v2}, 3'b010);
        step();
        chk("t1 beat2", {bus.si_v0, bus.si_v1, bus.si_v2}, 3'b001);
        step();
        chk("t1 idle", {bus.si_v0, bus.si_v1, bus.si_v2}, 3'b000);
        step(SI_LAT - 3);
        chk("t1 early", bus.res_valid, 1'b0);
        step();
        chk("t1 res_valid", bus.res_valid, 1'b1);
        chk("t1 res", {bus.res_id, bus.res_tmin, bus.res_tmax, bus.res_miss, bus.res_shadow},
            {8'h11, 32'h4000_0000, 32'h40C0_0000, 1'b0, 1'b0});
        bus.res_ready = 1'b1;
        step();
        chk("t1 popped", bus.res_valid, 1'b0);

        // back-to-back, id 3 misses
        for (int k = 0; k < 6; k++) begin
            send(mk(32'(k), 32'h0, 32'h0, k == 3 ? NEG1 : ONE, 32'h0, 32'h0), 8'(k), 1'b0, 10, acc[k], ok);
            chk("t2 accept", ok, 1'b1);
            if (k > 0) chk("t2 accept gap", acc[k] - acc[k-1], 3);
        end
        bus.ray_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            wait_res("t2", 40);
            rc[k] = cyc;
            if (k == 0) chk("t2 latency", rc[0] - acc[0], SI_LAT + 1);
            else chk("t2 result gap", rc[k] - rc[k-1], 3);
            chk("t2 id/miss/tmin", {bus.res_id, bus.res_miss, bus.res_tmin}, {8'(k), k == 3, 32'(k)});
            step();
        end

        // backpressure: credit stops intake at FIFO_DEPTH rays
        bus.res_ready = 1'b0;
        n = 0; last = 0;
        for (int k = 0; k < 12; k++) begin
            send(mk(32'(k), 32'h0, 32'h0, ONE, 32'h0, 32'h0), 8'h20 + 8'(k), 1'b0, 4, a, ok);
            if (ok) begin
                n++;
                last = a;
            end
        end
        chk("t3 accepted", n, 8);
        chk("t3 ready low", bus.ray_ready, 1'b0);
        bus.ray_valid = 1'b0;
        while (cyc < last + SI_LAT) step();
        chk("t3 head", {bus.res_valid, bus.res_id}, {1'b1, 8'h20});
        // pop on the very edge the eighth result is pushed
        bus.res_ready = 1'b1;
        step();
        chk("t3 head after push+pop", {bus.res_valid, bus.res_id}, {1'b1, 8'h21});
        chk("t3 ready resumes", bus.ray_ready, 1'b1);
        for (int k = 1; k < 8; k++) begin
            wait_res("t3 drain", 10);
            chk("t3 drain id", bus.res_id, 8'h20 + 8'(k));
            step();
        end
        chk("t3 empty", bus.res_valid, 1'b0);

        // reset while rays are in flight
        for (int k = 0; k < 3; k++) begin
            send(mk(ONE, ONE, ONE, ONE, ONE, ONE), 8'h30 + 8'(k), 1'b0, 5, a, ok);
            chk("t4 accept", ok, 1'b1);
        end
        bus.ray_valid = 1'b0;
        step();
        chk("t4 at AX1", bus.si_v1, 1'b1);
        rst = 1'b0;
        #1;
        chk_zero("t4 in reset");
        step(2);
        rst = 1'b1;
        seen = 0;
        repeat (2 * SI_LAT) begin
            step();
            if (bus.res_valid) seen++;
        end
        chk("t4 no stale results", seen, 0);
        send(mk(32'h4040_0000, 32'h3FC0_0000, 32'h0, NEG1, 32'h0, 32'h0), 8'hA5, 1'b0, 5, a, ok);
        bus.ray_valid = 1'b0;
        chk("t4 accept A5", ok, 1'b1);
        wait_res("t4", 40);
        chk("t4 res", {bus.res_id, bus.res_tmin, bus.res_tmax, bus.res_miss, bus.res_shadow},
            {8'hA5, 32'h4040_0000, 32'h3FC0_0000, 1'b1, 1'b0});
        step();

        // shadow passthrough
        send(mk(ONE, ONE, ONE, ONE, ONE, ONE), 8'h5A, 1'b1, 5, a, ok);
        bus.ray_valid = 1'b0;
        chk("t5 beat0", {bus.si_v0, bus.si_isShadow}, 2'b11);
        step();
        chk("t5 beat1", {bus.si_v1, bus.si_isShadow}, 2'b11);
        step();
        chk("t5 beat2", {bus.si_v2, bus.si_isShadow}, 2'b11);
        wait_res("t5", 40);
        chk("t5 res", {bus.res_id, bus.res_shadow}, {8'h5A, 1'b1});
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
